// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / interrupt unit: CSR
// addresses, operation and FSM encodings, status bit positions, cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIME     = 12'h7C0;
  localparam logic [11:0] CSR_MTIMEH    = 12'h7C1;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C2;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C3;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_REQ = 1'b1
  } trap_state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int CAUSE_TIMER    = 7;
  localparam int CAUSE_EXT_BASE = 16;

  // Value a CSR takes after applying a write/set/clear to its current value.
  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old_val | wdata;
      CSR_OP_CLEAR: return old_val & ~wdata;
      default:      return old_val;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser for one asynchronous interrupt line.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic irq_sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw line in at the bottom of the chain.
  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(irq_async);
  end

  // Chain register, cleared by reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign irq_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file, 64-bit machine timer, interrupt prioritisation and
// the request/acknowledge trap handshake with the hazard unit.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int VECTORED_EN = 1,
  parameter int TIMER_EN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [1:0]         csr_op,
  output logic [31:0]        csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mret,
  output logic               trap_req,
  output logic [31:0]        trap_pc,
  input  logic               trap_ack,
  input  logic [31:0]        epc,
  output logic [31:0]        ret_pc
);

  // Implemented bits of mie/mip: timer bit plus one bit per external line.
  localparam logic [31:0] IRQ_MASK = ((32'(1) << NUM_IRQ) - 32'd1) << CAUSE_EXT_BASE;
  localparam logic [31:0] IMPL_MASK = IRQ_MASK | (32'(1) << CAUSE_TIMER);

  trap_state_e state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic               mtip;
  logic [31:0]        mip;
  logic [31:0]        pending;
  logic [4:0]         irq_code;
  logic [31:0]        vec_base;
  logic [31:0]        vec_pc;
  logic [31:0]        wr_val;

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
      .clk       (clk),
      .reset     (reset),
      .irq_async (irq[k]),
      .irq_sync_o(irq_s[k])
    );
  end

  assign mtip = (TIMER_EN != 0) && (mtime_q >= mtimecmp_q);

  // Pending vector and the winning cause code (lowest external index first,
  // timer only when no external line is pending).
  // NOTE: every always_comb output is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    mip = '0;
    mip[CAUSE_TIMER] = mtip;
    mip[CAUSE_EXT_BASE +: NUM_IRQ] = irq_s;
    pending = mip & mie_q & {32{mstatus_mie_q}};
    irq_code = 5'(CAUSE_TIMER);
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pending[CAUSE_EXT_BASE + k]) irq_code = 5'(CAUSE_EXT_BASE + k);
    end
  end

  // Handler address: base, plus 4*code when vectored mode is enabled.
  always_comb begin
    vec_base = {mtvec_q[31:2], 2'b00};
    if ((VECTORED_EN != 0) && (mtvec_q[1:0] == 2'b01))
      vec_pc = vec_base + {25'b0, irq_code, 2'b00};
    else
      vec_pc = vec_base;
  end

  // Combinational CSR read of the addressed register.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mstatus_mie_q;
        csr_rdata[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MIP:       csr_rdata = mip;
      CSR_MTIME:     csr_rdata = (TIMER_EN != 0) ? mtime_q[31:0]     : '0;
      CSR_MTIMEH:    csr_rdata = (TIMER_EN != 0) ? mtime_q[63:32]    : '0;
      CSR_MTIMECMP:  csr_rdata = (TIMER_EN != 0) ? mtimecmp_q[31:0]  : '0;
      CSR_MTIMECMPH: csr_rdata = (TIMER_EN != 0) ? mtimecmp_q[63:32] : '0;
      default:       csr_rdata = '0;
    endcase
  end

  // Next state: CSR write first, then mret / trap FSM, whose updates to
  // mepc, mcause and mstatus take priority over a same-cycle write.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtime_d        = mtime_q + 64'd1;
    mtimecmp_d     = mtimecmp_q;
    cause_d        = cause_q;
    trap_pc_d      = trap_pc_q;
    wr_val         = csr_apply(csr_op_e'(csr_op), csr_rdata, csr_wdata);

    if (csr_op_e'(csr_op) != CSR_OP_NONE) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_val[MSTATUS_MIE];
          mstatus_mpie_d = wr_val[MSTATUS_MPIE];
        end
        CSR_MIE:       mie_d = wr_val & IMPL_MASK;
        CSR_MTVEC:     mtvec_d = wr_val;
        CSR_MEPC:      mepc_d = {wr_val[31:2], 2'b00};
        CSR_MCAUSE:    mcause_d = wr_val;
        // A write to either half of mtime suppresses that cycle's increment.
        CSR_MTIME:     mtime_d = {mtime_q[63:32], wr_val};
        CSR_MTIMEH:    mtime_d = {wr_val, mtime_q[31:0]};
        CSR_MTIMECMP:  mtimecmp_d[31:0]  = wr_val;
        CSR_MTIMECMPH: mtimecmp_d[63:32] = wr_val;
        default: ;
      endcase
    end

    case (state_q)
      ST_RUN: begin
        if (mret) begin
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
        end else if (pending != '0) begin
          cause_d   = 32'h8000_0000 | {27'b0, irq_code};
          trap_pc_d = vec_pc;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          mepc_d         = {epc[31:2], 2'b00};
          mcause_d       = cause_q;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          state_d        = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Register bank; reset aborts any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtime_q        <= '0;
      mtimecmp_q     <= '1;
      cause_q        <= '0;
      trap_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
      cause_q        <= cause_d;
      trap_pc_q      <= trap_pc_d;
    end
  end

  assign trap_req = (state_q == ST_REQ);
  assign trap_pc  = trap_pc_q;
  assign ret_pc   = mepc_q;

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_csr_irq_unit;

  localparam int NI = 4;
  localparam int SS = 2;
  localparam logic [31:0] IMPL_MASK = 32'h000F_0080;

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic [1:0]    csr_op;
  logic [31:0]   csr_rdata;
  logic [NI-1:0] irq;
  logic          mret;
  logic          trap_req;
  logic [31:0]   trap_pc;
  logic          trap_ack;
  logic [31:0]   epc;
  logic [31:0]   ret_pc;

  int errors = 0;
  int checks = 0;

  csr_irq_unit #(.NUM_IRQ(NI), .SYNC_STAGES(SS), .VECTORED_EN(1), .TIMER_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .csr_addr (csr_addr),
    .csr_wdata(csr_wdata),
    .csr_op   (csr_op),
    .csr_rdata(csr_rdata),
    .irq      (irq),
    .mret     (mret),
    .trap_req (trap_req),
    .trap_pc  (trap_pc),
    .trap_ack (trap_ack),
    .epc      (epc),
    .ret_pc   (ret_pc)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [31:0]   m_mie, m_mtvec, m_mepc, m_mcause, m_cause, m_tpc;
  logic          m_gie, m_mpie, m_req;
  logic [63:0]   m_mtime, m_cmp;
  logic [NI-1:0] m_line [$];   // irq samples in flight; [0] is what mip shows

  function automatic logic [31:0] m_mip();
    logic [31:0] v;
    v = '0;
    v[7] = (m_mtime >= m_cmp);
    v[16 +: NI] = m_line[0];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'b0, m_mpie, 3'b0, m_gie, 3'b0};
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
      12'h7C0: return m_mtime[31:0];
      12'h7C1: return m_mtime[63:32];
      12'h7C2: return m_cmp[31:0];
      12'h7C3: return m_cmp[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cause = 0; m_tpc = 0;
    m_gie = 0; m_mpie = 0; m_req = 0; m_mtime = 0; m_cmp = '1;
    m_line.delete();
    for (int i = 0; i < SS; i++) m_line.push_back('0);
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    logic [31:0] pend, old, nv, base;
    logic [31:0] n_mie, n_mtvec, n_mepc, n_mcause, n_cause, n_tpc;
    logic [63:0] n_mtime, n_cmp;
    logic        n_gie, n_mpie, n_req;
    int          code;
    pend = m_mip() & m_mie & (m_gie ? 32'hFFFF_FFFF : 32'h0);
    n_mie = m_mie; n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
    n_cause = m_cause; n_tpc = m_tpc; n_gie = m_gie; n_mpie = m_mpie; n_req = m_req;
    n_mtime = m_mtime + 64'd1; n_cmp = m_cmp;
    if (csr_op != 2'b00) begin
      old = m_read(csr_addr);
      case (csr_op)
        2'b01:   nv = csr_wdata;
        2'b10:   nv = old | csr_wdata;
        default: nv = old & ~csr_wdata;
      endcase
      case (csr_addr)
        12'h300: begin n_gie = nv[3]; n_mpie = nv[7]; end
        12'h304: n_mie = nv & IMPL_MASK;
        12'h305: n_mtvec = nv;
        12'h341: n_mepc = nv & ~32'h3;
        12'h342: n_mcause = nv;
        12'h7C0: n_mtime = {m_mtime[63:32], nv};
        12'h7C1: n_mtime = {nv, m_mtime[31:0]};
        12'h7C2: n_cmp = {m_cmp[63:32], nv};
        12'h7C3: n_cmp = {nv, m_cmp[31:0]};
        default: ;
      endcase
    end
    if (!m_req) begin
      if (mret) begin
        n_gie = m_mpie; n_mpie = 1'b1;
      end else if (pend != 0) begin
        code = -1;
        for (int k = 0; k < NI; k++) if (code < 0 && pend[16 + k]) code = 16 + k;
        if (code < 0) code = 7;
        base = m_mtvec & ~32'h3;
        n_req = 1'b1;
        n_cause = 32'h8000_0000 + 32'(code);
        n_tpc = (m_mtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
      end
    end else if (trap_ack) begin
      n_mepc = epc & ~32'h3; n_mcause = m_cause;
      n_mpie = m_gie; n_gie = 1'b0; n_req = 1'b0;
    end
    m_line.push_back(irq);
    void'(m_line.pop_front());
    m_mie = n_mie; m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
    m_cause = n_cause; m_tpc = n_tpc; m_gie = n_gie; m_mpie = n_mpie; m_req = n_req;
    m_mtime = n_mtime; m_cmp = n_cmp;
  endtask

  // Stimulus helpers (no comparisons here)
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 0;
    irq = '0; mret = 0; trap_ack = 0; epc = 0;
    model_reset();
    #3;
    reset = 1'b0;
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_op = 2'b01;
    tick();
    csr_op = 2'b00;
  endtask

  task automatic ack(input logic [31:0] pc);
    trap_ack = 1'b1; epc = pc;
    tick();
    trap_ack = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = trap_req;
    end
  endtask

  task automatic test_reset();
    logic [11:0] addrs [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h7C3};
    logic [31:0] exps  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    do_reset();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL reset_trap_req: got %0b want 0", trap_req); end
    checks++; if (trap_pc !== 32'h0) begin errors++; $display("FAIL reset_trap_pc: got %h want 0", trap_pc); end
    checks++; if (ret_pc !== 32'h0) begin errors++; $display("FAIL reset_ret_pc: got %h want 0", ret_pc); end
    for (int i = 0; i < 6; i++) begin
      csr_addr = addrs[i]; #1;
      checks++;
      if (csr_rdata !== exps[i]) begin
        errors++; $display("FAIL reset_csr_%h: got %h want %h", addrs[i], csr_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_direct();
    do_reset();
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'h0001_0000);
    csr_write(12'h300, 32'h0000_0008);
    irq[0] = 1'b1;
    csr_addr = 12'h344;
    for (int i = 0; i < SS; i++) tick();
    checks++; if (csr_rdata !== 32'h0001_0000) begin errors++; $display("FAIL direct_mip: got %h want 00010000", csr_rdata); end
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL direct_req_early: got %0b want 0", trap_req); end
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL direct_req: got %0b want 1", trap_req); end
    checks++; if (trap_pc !== 32'h100) begin errors++; $display("FAIL direct_trap_pc: got %h want 00000100", trap_pc); end
    ack(32'h44);
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL direct_req_drop: got %0b want 0", trap_req); end
    checks++; if (ret_pc !== 32'h44) begin errors++; $display("FAIL direct_mepc: got %h want 00000044", ret_pc); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0010) begin errors++; $display("FAIL direct_mcause: got %h want 80000010", csr_rdata); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL direct_mstatus: got %h want 00000080", csr_rdata); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL direct_no_rereq: got %0b want 0", trap_req); end
    irq = '0;
  endtask

  task automatic test_vectored();
    bit seen;
    do_reset();
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0005_0000);
    csr_write(12'h300, 32'h0000_0008);
    irq = 4'b0101;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL vec_first_timeout: got no trap_req want 1"); end
    checks++; if (trap_pc !== 32'h240) begin errors++; $display("FAIL vec_first_pc: got %h want 00000240", trap_pc); end
    irq = 4'b0100;   // source 0 drops while the request is outstanding
    for (int i = 0; i < SS + 2; i++) begin
      tick();
      checks++;
      if (trap_req !== 1'b1 || trap_pc !== 32'h240) begin
        errors++; $display("FAIL vec_hold: got req=%0b pc=%h want req=1 pc=00000240", trap_req, trap_pc);
      end
    end
    ack(32'h80);
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0010) begin errors++; $display("FAIL vec_first_cause: got %h want 80000010", csr_rdata); end
    mret = 1'b1; tick(); mret = 1'b0;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL vec_second_timeout: got no trap_req want 1"); end
    checks++; if (trap_pc !== 32'h248) begin errors++; $display("FAIL vec_second_pc: got %h want 00000248", trap_pc); end
    ack(32'h90);
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0012) begin errors++; $display("FAIL vec_second_cause: got %h want 80000012", csr_rdata); end
    irq = '0;
  endtask

  task automatic test_timer();
    bit hit;
    do_reset();
    csr_write(12'h7C2, 32'd20);
    csr_write(12'h7C3, 32'd0);
    csr_write(12'h7C0, 32'd0);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    csr_addr = 12'h344;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = csr_rdata[7];
    end
    checks++; if (!hit) begin errors++; $display("FAIL timer_mip_timeout: got no mip bit 7 want 1"); end
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL timer_mip: got %h want 00000080", csr_rdata); end
    csr_addr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'd20) begin errors++; $display("FAIL timer_mtime: got %0d want 20", csr_rdata); end
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL timer_req: got %0b want 1", trap_req); end
    ack(32'h10);
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL timer_cause: got %h want 80000007", csr_rdata); end
    csr_write(12'h7C3, 32'hFFFF_FFFF);
    csr_addr = 12'h344; #1;
    checks++; if (csr_rdata[7] !== 1'b0) begin errors++; $display("FAIL timer_mip_clear: got %0b want 0", csr_rdata[7]); end
  endtask

  task automatic test_conflict();
    bit seen;
    do_reset();
    csr_write(12'h304, 32'h0002_0000);
    csr_write(12'h300, 32'h8);
    irq = 4'b0010;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL conflict_timeout: got no trap_req want 1"); end
    csr_addr = 12'h341; csr_wdata = 32'h500; csr_op = 2'b01;
    ack(32'h60);
    csr_op = 2'b00;
    checks++; if (ret_pc !== 32'h60) begin errors++; $display("FAIL conflict_mepc: got %h want 00000060", ret_pc); end
    irq = '0;
  endtask

  task automatic test_masking();
    do_reset();
    csr_write(12'h304, 32'h0001_0000);
    irq[0] = 1'b1;
    csr_addr = 12'h344;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL mask_req: got %0b want 0", trap_req); end
    end
    checks++; if (csr_rdata !== 32'h0001_0000) begin errors++; $display("FAIL mask_mip: got %h want 00010000", csr_rdata); end
    csr_write(12'h300, 32'h8);
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL enable_req_early: got %0b want 0", trap_req); end
    tick();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL enable_req: got %0b want 1", trap_req); end
    irq = '0;
  endtask

  task automatic test_reset_in_req();
    bit seen;
    do_reset();
    csr_write(12'h304, 32'h0001_0000);
    csr_write(12'h300, 32'h8);
    irq[0] = 1'b1;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rreq_timeout: got no trap_req want 1"); end
    trap_ack = 1'b1; epc = 32'h99;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0; trap_ack = 1'b0;
    tick();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL rreq_req: got %0b want 0", trap_req); end
    checks++; if (ret_pc !== 32'h0) begin errors++; $display("FAIL rreq_mepc: got %h want 0", ret_pc); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rreq_mcause: got %h want 0", csr_rdata); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rreq_mstatus: got %h want 0", csr_rdata); end
    irq = '0;
  endtask

  task automatic test_random();
    logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h123};
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      csr_addr  = addrs[$urandom_range(0, 10)];
      csr_wdata = $urandom;
      if (csr_addr == 12'h300) csr_wdata = csr_wdata | 32'h8;   // favour enabled interrupts
      if (csr_addr == 12'h7C1 || csr_addr == 12'h7C3) csr_wdata = csr_wdata & 32'h1;
      csr_op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 7) == 0) irq = NI'($urandom);
      trap_ack  = m_req && ($urandom_range(0, 3) == 0);
      mret      = !m_req && ($urandom_range(0, 9) == 0);
      epc       = $urandom;
      tick();
      csr_op = 2'b00; trap_ack = 1'b0; mret = 1'b0;
      checks++;
      if (trap_req !== m_req) begin errors++; $display("FAIL rand_req cyc %0d: got %0b want %0b", i, trap_req, m_req); end
      if (m_req) begin
        checks++;
        if (trap_pc !== m_tpc) begin errors++; $display("FAIL rand_pc cyc %0d: got %h want %h", i, trap_pc, m_tpc); end
      end
      checks++;
      if (ret_pc !== m_mepc) begin errors++; $display("FAIL rand_ret_pc cyc %0d: got %h want %h", i, ret_pc, m_mepc); end
      csr_addr = addrs[$urandom_range(0, 10)]; #1;
      want = m_read(csr_addr);
      checks++;
      if (csr_rdata !== want) begin
        errors++; $display("FAIL rand_read_%h cyc %0d: got %h want %h", csr_addr, i, csr_rdata, want);
      end
    end
    irq = '0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_vectored();
    test_timer();
    test_conflict();
    test_masking();
    test_reset_in_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
